// File: rtl/display_scan_scheduler_pkg.sv
// Shared display definitions: scan FSM states, digit count and the anode decoder
// used by every block that drives the common-anode display.
package display_scan_scheduler_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {OFF, BLANK, ON, DIM} ScanState;

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_decode(input logic [2:0] idx);
    logic [NUM_DIGITS-1:0] oneHot;
    oneHot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    return ~oneHot;
  endfunction

endpackage

// File: rtl/display_scan_scheduler_digit_rr_select.sv
// Rotate-priority encoder: finds the next enabled digit strictly after i_ptr,
// searching upward and wrapping, with i_ptr itself as the last candidate.
module digit_rr_select
  import display_scan_scheduler_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] i_mask,
  input  logic [2:0]            i_ptr,
  output logic [2:0]            o_nextPtr,
  output logic                  o_wrap,
  output logic                  o_none
);

  logic [2:0] w_idx;

  // Walk candidates from farthest to nearest so the nearest enabled one wins.
  always_comb begin
    o_nextPtr = i_ptr;
    w_idx     = i_ptr;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      w_idx = i_ptr + 3'(k);
      if (i_mask[w_idx]) o_nextPtr = w_idx;
    end
  end

  assign o_wrap = (o_nextPtr <= i_ptr);
  assign o_none = (i_mask == '0);

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-slot scanner for the 8-digit display: blanking, brightness on-window
// and round-robin digit ownership over the enabled digits.
module display_scan_scheduler
  import display_scan_scheduler_pkg::*;
#(
  parameter int TICK_DIV  = 208333,
  parameter int BLANK_CYC = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [7:0] i_digit_mask,
  input  logic [2:0] i_bright,
  output logic [7:0] o_an,
  output logic [2:0] o_seg_sel,
  output logic       o_frame_start
);

  localparam int             CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW:0]    BLANK_END = (CW+1)'(BLANK_CYC);
  localparam logic [CW+3:0]  TICK_EXT  = (CW+4)'(TICK_DIV);

  ScanState      r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_ptr;
  logic [CW:0]   r_onLimit;
  logic [7:0]    r_an;
  logic [2:0]    r_segSel;
  logic          r_frameStart;

  logic [CW+3:0] w_onProduct;
  logic [CW:0]   w_onLimit;
  logic [CW:0]   w_cntInc;
  logic [2:0]    w_searchPtr;
  logic [2:0]    w_nextPtr;
  logic          w_wrap;
  logic          w_none;

  // Product is kept wide enough for 8*TICK_DIV so the shift sees every bit.
  assign w_onProduct = ((CW+4)'(i_bright) + (CW+4)'(1)) * TICK_EXT;
  assign w_onLimit   = (CW+1)'(w_onProduct >> 3);
  assign w_cntInc    = {1'b0, r_cnt} + (CW+1)'(1);

  // From OFF, searching after the top digit yields the lowest enabled digit.
  assign w_searchPtr = (r_state == OFF) ? 3'(NUM_DIGITS - 1) : r_ptr;

  digit_rr_select u_select (
    .i_mask    (i_digit_mask),
    .i_ptr     (w_searchPtr),
    .o_nextPtr (w_nextPtr),
    .o_wrap    (w_wrap),
    .o_none    (w_none)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= OFF;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_onLimit    <= '0;
      r_an         <= 8'hFF;
      r_segSel     <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= 1'b0;
      if (!i_en) begin
        r_state <= OFF;
        r_cnt   <= '0;
        r_ptr   <= '0;
        r_an    <= 8'hFF;
      end else if (r_state == OFF) begin
        if (!w_none) begin
          r_state      <= BLANK;
          r_cnt        <= '0;
          r_ptr        <= w_nextPtr;
          r_segSel     <= w_nextPtr;
          r_onLimit    <= w_onLimit;
          r_frameStart <= 1'b1;
          r_an         <= 8'hFF;
        end
      end else if (r_cnt == CNT_LAST) begin
        // Slot boundary: mask and brightness are sampled only here.
        r_cnt <= '0;
        r_an  <= 8'hFF;
        if (w_none) begin
          r_state <= OFF;
          r_ptr   <= '0;
        end else begin
          r_state      <= BLANK;
          r_ptr        <= w_nextPtr;
          r_segSel     <= w_nextPtr;
          r_onLimit    <= w_onLimit;
          r_frameStart <= w_wrap;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        case (r_state)
          BLANK: begin
            if (w_cntInc == BLANK_END) begin
              r_state <= ON;
              r_an    <= anode_decode(r_ptr);
            end
          end
          ON: begin
            if (w_cntInc == r_onLimit) begin
              r_state <= DIM;
              r_an    <= 8'hFF;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_an          = r_an;
  assign o_seg_sel     = r_segSel;
  assign o_frame_start = r_frameStart;

endmodule
